collision_detect: RTL

Per-frame collision checker between the frog and the car set. On each frame-start pulse it snapshots the frog's top-left corner and every car's top-left corner, then tests the cars one per clock. On the first overlap it emits a single-cycle collision pulse for the frog movement logic, followed by a grace period. It sits between the car/lane generators and the frog movement block, and drives that block's collision input.

---
 rtl/collision_detect_pkg.sv | 16 +
 rtl/collision_detect_aabb.sv | 32 +++
 rtl/collision_detect.sv | 125 ++++++++++++
 3 files changed

// File: rtl/collision_detect_pkg.sv
// Shared constants and FSM encoding for the frog/car collision checker.
package collision_detect_pkg;

    localparam int COORD_W        = 10;
    localparam int TILE_SIZE      = 32;
    localparam int H_VISIBLE_AREA = 640;
    localparam int V_VISIBLE_AREA = 480;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        HIT   = 2'd2,
        GRACE = 2'd3
    } state_t;

endpackage

// File: rtl/collision_detect_aabb.sv
// Combinational axis-aligned box overlap test; edge-touching boxes do not overlap.
module aabb_overlap
    import collision_detect_pkg::*;
#(
    parameter int A_W = TILE_SIZE,
    parameter int A_H = TILE_SIZE,
    parameter int B_W = 2 * TILE_SIZE,
    parameter int B_H = TILE_SIZE
)(
    input  logic [COORD_W-1:0] a_x,
    input  logic [COORD_W-1:0] a_y,
    input  logic [COORD_W-1:0] b_x,
    input  logic [COORD_W-1:0] b_y,
    output logic               overlap
);

    localparam int SUM_W = COORD_W + 1;

    // One spare bit so coordinate + size never wraps near the screen edge.
    logic [SUM_W-1:0] ax, ay, bx, by;

    assign ax = {1'b0, a_x};
    assign ay = {1'b0, a_y};
    assign bx = {1'b0, b_x};
    assign by = {1'b0, b_y};

    assign overlap = (ax < bx + SUM_W'(B_W)) &&
                     (bx < ax + SUM_W'(A_W)) &&
                     (ay < by + SUM_W'(B_H)) &&
                     (by < ay + SUM_W'(A_H));

endmodule

// File: rtl/collision_detect.sv
// Per-frame frog/car collision scanner: snapshot on frame start, one car per clock,
// single-cycle pulse on the first hit, then a grace period counted in frames.
module collision_detect
    import collision_detect_pkg::*;
#(
    parameter int NUM_CARS     = 8,
    parameter int TILE_SIZE    = collision_detect_pkg::TILE_SIZE,
    parameter int CAR_W        = 64,
    parameter int GRACE_FRAMES = 2
)(
    input  logic                        i_Clk,
    input  logic                        i_Rst_L,
    input  logic                        i_Frame_Start,
    input  logic [COORD_W-1:0]          i_Frog_X,
    input  logic [COORD_W-1:0]          i_Frog_Y,
    input  logic [COORD_W*NUM_CARS-1:0] i_Car_X,
    input  logic [COORD_W*NUM_CARS-1:0] i_Car_Y,
    input  logic [NUM_CARS-1:0]         i_Car_Valid,
    output logic                        o_Has_Collided,
    output logic [3:0]                  o_Hit_Index,
    output logic                        o_Busy,
    output logic [7:0]                  o_Collision_Count
);

    localparam int               IDX_W      = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;
    localparam int               SLOTS      = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_CARS - 1);
    localparam logic [3:0]       GRACE_INIT = 4'(GRACE_FRAMES);

    state_t             state, state_nx;
    logic [IDX_W-1:0]   idx;
    logic [3:0]         grace_cnt;
    logic [COORD_W-1:0] snap_frog_x, snap_frog_y;
    logic [COORD_W-1:0] snap_car_x [SLOTS];
    logic [COORD_W-1:0] snap_car_y [SLOTS];
    logic [SLOTS-1:0]   snap_valid;
    logic               overlap;
    logic               hit;

    // Slots past NUM_CARS stay at their reset value, so they never report a hit.
    aabb_overlap #(
        .A_W (TILE_SIZE),
        .A_H (TILE_SIZE),
        .B_W (CAR_W),
        .B_H (TILE_SIZE)
    ) u_overlap (
        .a_x     (snap_frog_x),
        .a_y     (snap_frog_y),
        .b_x     (snap_car_x[idx]),
        .b_y     (snap_car_y[idx]),
        .overlap (overlap)
    );

    assign hit = snap_valid[idx] && overlap;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) state <= IDLE;
        else          state <= state_nx;
    end

    // NOTE: next state defaults to the current state first, so no path infers a latch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_Frame_Start) state_nx = SCAN;
            SCAN:    if (hit)                  state_nx = HIT;
                     else if (idx == LAST_IDX) state_nx = IDLE;
            HIT:     state_nx = GRACE;
            GRACE:   if (i_Frame_Start && grace_cnt <= 4'd1) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_Has_Collided = (state == HIT);
        o_Busy         = (state == SCAN);
    end

    // NOTE: the snapshot array is small and explicitly cleared on reset, so no stale car can hit after reset.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            idx               <= '0;
            grace_cnt         <= '0;
            o_Hit_Index       <= '0;
            o_Collision_Count <= '0;
            snap_frog_x       <= '0;
            snap_frog_y       <= '0;
            snap_valid        <= '0;
            for (int k = 0; k < SLOTS; k++) begin
                snap_car_x[k] <= '0;
                snap_car_y[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (i_Frame_Start) begin
                        idx         <= '0;
                        snap_frog_x <= i_Frog_X;
                        snap_frog_y <= i_Frog_Y;
                        for (int k = 0; k < NUM_CARS; k++) begin
                            snap_car_x[k] <= i_Car_X[COORD_W*k +: COORD_W];
                            snap_car_y[k] <= i_Car_Y[COORD_W*k +: COORD_W];
                            snap_valid[k] <= i_Car_Valid[k];
                        end
                    end
                end
                SCAN: begin
                    // Index and count move on the edge that enters HIT, aligned with the pulse.
                    if (hit) begin
                        o_Hit_Index <= 4'(idx);
                        if (o_Collision_Count != 8'hFF)
                            o_Collision_Count <= o_Collision_Count + 8'd1;
                    end else if (idx != LAST_IDX) begin
                        idx <= idx + 1'b1;
                    end
                end
                HIT:   grace_cnt <= GRACE_INIT;
                GRACE: if (i_Frame_Start && grace_cnt != 4'd0) grace_cnt <= grace_cnt - 4'd1;
                default: ;
            endcase
        end
    end

endmodule
